alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: InValid  in  1  upstream instruction valid.
REQ-005 SHALL have: InReady  out  1  upstream may transfer (transfer = InValid & InReady).
REQ-006 SHALL have: Instr  in  32  RV32I instruction word.
REQ-007 SHALL have: PC  in  32  instruction address; used only for AUIPC.
REQ-008 SHALL have: RS1Data  in  32, and RS2Data  in  32: register operands.
REQ-009 SHALL have: Flush  in  1  discard all buffered and incoming entries.
REQ-010 SHALL have: OutValid  out  1, and OutReady  in  1: ALU-side handshake.
REQ-011 SHALL have: A  out  32, B  out  32, ALUOp  out  4: ALU operands and op code.
REQ-012 SHALL have: Rd  out  5 (Instr[11:7]), and Illegal  out  1 (undecodable instruction).

Function
REQ-013 SHALL decode opcode 0110011 (OP): A=RS1Data, B=RS2Data; funct3/funct7 map 000/0000000 ADD 0000, 000/0100000 SUB 0001, 111 AND 0010, 110 OR 0011, 100 XOR 0100, 001 SLL 0101, 101/0000000 SRL 0110, 101/0100000 SRA 0111, 010 SLT 1000, 011 SLTU 1001.
REQ-014 SHALL require funct7=0000000 on OP rows not listed with 0100000; any other funct7 is illegal.
REQ-015 SHALL decode opcode 0010011 (OP-IMM) with the same funct3 mapping (no SUB), A=RS1Data, B=sign-extended Instr[31:20].
REQ-016 SHALL, for OP-IMM shifts, use B={27'b0,Instr[24:20]}; funct3 001 requires Instr[31:25]=0000000; funct3 101 accepts 0000000 (SRL) or 0100000 (SRA); else illegal.
REQ-017 SHALL, for illegal/unsupported instructions, emit the entry with Illegal=1, A=0, B=0, ALUOp=0000, Rd passed through.
REQ-018 SHALL provide two-entry buffering (output register + skid register); InReady = !skid-valid, driven from a register.
REQ-019 SHALL present an accepted instruction on the outputs the cycle after transfer when the output register is empty or draining (latency 1).
REQ-020 SHALL preserve order; no entry lost or duplicated under any OutReady pattern.
REQ-021 SHALL hold A, B, ALUOp, Rd, Illegal stable while OutValid=1 and OutReady=0.
REQ-022 SHALL sustain one transfer per cycle when OutReady=1 continuously.
REQ-023 SHALL, on Flush=1, clear both entries next cycle and ignore a same-cycle input transfer; OutValid=0 and InReady=1 next cycle.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, clear both entries: OutValid=0, InReady=1, A=B=0, ALUOp=0000, Rd=0, Illegal=0 next cycle.
REQ-025 SHALL give reset priority over Flush and over any handshake, including mid-stall.

Configuration
REQ-026 SHALL, with macro ALU_ISSUE_UPPER_EN defined, decode LUI (0110111: A=0) and AUIPC (0010111: A=PC), both with B={Instr[31:12],12'b0}, ALUOp=0000.
REQ-027 SHALL, without ALU_ISSUE_UPPER_EN, treat LUI and AUIPC as illegal and leave PC unused.

Structure
REQ-028 SHALL place ALUOp constants (ALU_ADD..ALU_SLTU) and opcode constants in shared package alu_pkg, also used by the ALU.
REQ-029 SHALL isolate decoding in one combinational sub-module alu_issue_dec, instantiated once ahead of the buffer.

Verification
REQ-030 SHALL cover: Instr=0x002081B3 (ADD x3,x1,x2), RS1=5, RS2=7, OutReady=1 -> next cycle OutValid=1, A=5, B=7, ALUOp=0000, Rd=3.
REQ-031 SHALL cover: Instr=0x40435293 (SRAI x5,x6,4), RS1=0x80000000 -> ALUOp=0111, B=4, Rd=5, Illegal=0.
REQ-032 SHALL cover: OutReady=0, three back-to-back valid inputs -> two accepted, InReady=0 after second; OutReady=1 -> all three emitted in order, third accepted once InReady=1.
REQ-033 SHALL cover: Instr=0x022081B3 (MUL) -> Illegal=1, ALUOp=0000, A=B=0, Rd=3.
REQ-034 SHALL cover: two entries buffered, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, flushed input never emitted.
REQ-035 SHALL cover: Instr=0x123450B7 (LUI x1,0x12345) -> with ALU_ISSUE_UPPER_EN A=0, B=0x12345000, Illegal=0; without it Illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode constants and the issue entry
// carried from the decoder through the issue buffer to the ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;

  // Base funct3 mapping shared by OP and OP-IMM; SUB/SRA are chosen by funct7.
  function automatic alu_op_e f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I ALU decoder producing one issue entry.
// LUI/AUIPC are decoded only when ALU_ISSUE_UPPER_EN is defined.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1,
  input  logic [31:0]  rs2,
  output issue_entry_t ent
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    legal = 1'b0;
    op    = f3_op(f3);
    a     = rs1;
    b     = rs2;
    case (opcode)
      OPC_OP: begin
        case (f3)
          3'b000: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            if (f7 == F7_ALT) op = ALU_SUB;
          end
          3'b101: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            if (f7 == F7_ALT) op = ALU_SRA;
          end
          default: legal = (f7 == F7_BASE);
        endcase
      end
      OPC_OP_IMM: begin
        b = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b001: begin
            b     = {27'b0, instr[24:20]};
            legal = (f7 == F7_BASE);
          end
          3'b101: begin
            b     = {27'b0, instr[24:20]};
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            if (f7 == F7_ALT) op = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
`ifdef ALU_ISSUE_UPPER_EN
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_ADD;
        a     = '0;
        b     = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op    = ALU_ADD;
        a     = pc;
        b     = {instr[31:12], 12'b0};
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries still travel through the buffer so the ALU side can trap in order.
  always_comb begin
    ent.a       = legal ? a : '0;
    ent.b       = legal ? b : '0;
    ent.op      = legal ? op : ALU_ADD;
    ent.rd      = instr[11:7];
    ent.illegal = !legal;
  end

`ifndef ALU_ISSUE_UPPER_EN
  logic unused_upper;
  assign unused_upper = ^{pc, instr[19:15]};
`else
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];
`endif

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an RV32I ALU instruction and holds it in a
// two-entry (output + skid) buffer. Optional LUI/AUIPC via ALU_ISSUE_UPPER_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] RS1Data,
  input  logic [XLEN-1:0] RS2Data,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALUOp,
  output logic [4:0]      Rd,
  output logic            Illegal
);

  // Handshake: a beat moves on a rising edge when valid and ready are both 1;
  // a valid beat's payload is held unchanged until it moves, and ready never
  // depends combinationally on valid (InReady comes straight from a flop).

  issue_entry_t dec_ent;
  issue_entry_t out_q;
  issue_entry_t skid_q;
  logic         out_v;
  logic         skid_v;
  logic         in_rdy;
  logic         take;

  alu_issue_dec u_dec (
    .instr (Instr),
    .pc    (PC),
    .rs1   (RS1Data),
    .rs2   (RS2Data),
    .ent   (dec_ent)
  );

  assign take = InValid && in_rdy;

  // in_rdy always equals !skid_v; kept as its own flop so InReady is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      in_rdy <= 1'b1;
    end else if (Flush) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      in_rdy <= 1'b1;
    end else if (!out_v || OutReady) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
        in_rdy <= 1'b1;
      end else begin
        out_v <= take;
        if (take) out_q <= dec_ent;
      end
    end else if (take) begin
      skid_q <= dec_ent;
      skid_v <= 1'b1;
      in_rdy <= 1'b0;
    end
  end

  assign InReady  = in_rdy;
  assign OutValid = out_v;
  assign A        = out_q.a;
  assign B        = out_q.b;
  assign ALUOp    = out_q.op;
  assign Rd       = out_q.rd;
  assign Illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus random traffic, with a
// reference decoder feeding an expected-entry queue checked at each output beat.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] RS1Data;
  logic [31:0] RS2Data;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUOp;
  logic [4:0]  Rd;
  logic        Illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [73:0] exp_q[$];
  logic [73:0] out_vec;
  logic        hold_pending = 1'b0;
  logic [73:0] hold_val;

  assign out_vec = {A, B, ALUOp, Rd, Illegal};

  alu_issue #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Instr    (Instr),
    .PC       (PC),
    .RS1Data  (RS1Data),
    .RS2Data  (RS2Data),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .Rd       (Rd),
    .Illegal  (Illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder, written from the ISA tables.
  function automatic logic [73:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ok;
    logic [3:0]  base;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ok  = 1'b0;
    a   = 32'h0;
    b   = 32'h0;
    case (f3)
      3'd0: base = 4'd0;
      3'd1: base = 4'd5;
      3'd2: base = 4'd8;
      3'd3: base = 4'd9;
      3'd4: base = 4'd4;
      3'd5: base = 4'd6;
      3'd6: base = 4'd3;
      default: base = 4'd2;
    endcase
    op = base;
    if (opc == 7'h33) begin
      a = r1;
      b = r2;
      if (f7 == 7'h00) ok = 1'b1;
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; op = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 4'd7; end
    end else if (opc == 7'h13) begin
      a = r1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        b = {27'd0, ins[24:20]};
        if (f7 == 7'h00) ok = 1'b1;
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 4'd7; end
      end else begin
        b  = {{20{ins[31]}}, ins[31:20]};
        ok = 1'b1;
      end
    end
`ifdef ALU_ISSUE_UPPER_EN
    else if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1'b1;
      op = 4'd0;
      a  = (opc == 7'h17) ? pc : 32'h0;
      b  = {ins[31:12], 12'h000};
    end
`endif
    if (!ok) begin
      a  = 32'h0;
      b  = 32'h0;
      op = 4'd0;
    end
    return {a, b, op, ins[11:7], !ok};
  endfunction

  // scoreboard: inputs/outputs are stable at negedge, so the coming edge's transfers are known here
  always @(negedge clk) begin
    if (hold_pending) check("hold", {1'b1, out_vec}, {1'b1, hold_val});
    hold_pending = 1'b0;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (OutValid && !OutReady && !Flush) begin
        hold_pending = 1'b1;
        hold_val     = out_vec;
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) check("unexpected_out", {6'd0, out_vec}, 80'd0);
        else check("sb_out", {6'd0, out_vec}, {6'd0, exp_q.pop_front()});
      end
      if (Flush) exp_q.delete();
      else if (InValid && InReady) exp_q.push_back(model(Instr, PC, RS1Data, RS2Data));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    InValid = 1'b1;
    Instr   = ins;
    RS1Data = r1;
    RS2Data = r2;
    PC      = $urandom;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 4))
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h37;
      3: ins[6:0] = 7'h17;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    reset = 1'b1; InValid = 1'b0; Instr = '0; PC = '0;
    RS1Data = '0; RS2Data = '0; Flush = 1'b0; OutReady = 1'b0;
    step();
    step();
    check("rst_outvalid", {79'd0, OutValid}, 80'd0);
    check("rst_inready", {79'd0, InReady}, 80'd1);
    check("rst_payload", {6'd0, out_vec}, 80'd0);
    reset = 1'b0;
    step();

    // ADD x3,x1,x2: latency 1
    OutReady = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7);
    step();
    InValid = 1'b0;
    check("add_valid", {79'd0, OutValid}, 80'd1);
    check("add_payload", {6'd0, out_vec}, {6'd0, 32'd5, 32'd7, 4'h0, 5'd3, 1'b0});

    // SRAI x5,x6,4
    drive(32'h40435293, 32'h80000000, 32'h0);
    step();
    InValid = 1'b0;
    check("srai_payload", {6'd0, out_vec}, {6'd0, 32'h80000000, 32'd4, 4'h7, 5'd5, 1'b0});

    // MUL is not an ALU op
    drive(32'h022081B3, 32'd9, 32'd11);
    step();
    InValid = 1'b0;
    check("mul_payload", {6'd0, out_vec}, {6'd0, 32'd0, 32'd0, 4'h0, 5'd3, 1'b1});

    // LUI x1,0x12345
    drive(32'h123450B7, 32'hdeadbeef, 32'h0);
    step();
    InValid = 1'b0;
`ifdef ALU_ISSUE_UPPER_EN
    check("lui_payload", {6'd0, out_vec}, {6'd0, 32'd0, 32'h12345000, 4'h0, 5'd1, 1'b0});
`else
    check("lui_payload", {6'd0, out_vec}, {6'd0, 32'd0, 32'd0, 4'h0, 5'd1, 1'b1});
`endif
    step();

    // stall: three back-to-back inputs with OutReady low
    OutReady = 1'b0;
    drive(32'h00000093 | (32'd1 << 20), 32'd100, 32'd0);  // ADDI x1,x0,1
    step();
    check("stall_rdy1", {79'd0, InReady}, 80'd1);
    drive(32'h002081B3, 32'd200, 32'd1);
    step();
    check("stall_rdy2", {79'd0, InReady}, 80'd0);
    drive(32'h4020C233, 32'd300, 32'd2);
    step();
    check("stall_rdy3", {79'd0, InReady}, 80'd0);
    check("stall_head", {6'd0, out_vec}, {6'd0, 32'd100, 32'd1, 4'h0, 5'd1, 1'b0});
    OutReady = 1'b1;
    step();
    check("unstall_rdy", {79'd0, InReady}, 80'd1);
    step();
    InValid = 1'b0;
    step();
    step();
    check("stall_empty", {79'd0, OutValid}, 80'd0);

    // sustained throughput
    for (int i = 0; i < 4; i++) begin
      drive(rand_instr(), $urandom, $urandom);
      step();
      check("tput_valid", {78'd0, OutValid, InReady}, {78'd0, 2'b11});
    end
    InValid = 1'b0;
    step();

    // flush with two buffered and a same-cycle input
    OutReady = 1'b0;
    drive(32'h002081B3, 32'd1, 32'd2);
    step();
    drive(32'h00208233, 32'd3, 32'd4);
    step();
    drive(32'h002082B3, 32'd5, 32'd6);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    check("flush_state", {78'd0, OutValid, InReady}, {78'd0, 2'b01});
    OutReady = 1'b1;
    step();
    step();

    // reset mid-stall beats flush and handshake
    OutReady = 1'b0;
    drive(32'h002081B3, 32'd7, 32'd8);
    step();
    drive(32'h00208233, 32'd9, 32'd10);
    step();
    reset = 1'b1;
    Flush = 1'b1;
    step();
    reset = 1'b0;
    Flush = 1'b0;
    InValid = 1'b0;
    check("rst2_state", {78'd0, OutValid, InReady}, {78'd0, 2'b01});
    check("rst2_payload", {6'd0, out_vec}, 80'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) drive(rand_instr(), $urandom, $urandom);
      else InValid = 1'b0;
      OutReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 39) == 0);
      step();
    end
    InValid  = 1'b0;
    Flush    = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    step();
    check("sb_drained", {48'd0, exp_q.size()}, 80'd0);
    check("final_valid", {79'd0, OutValid}, 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
